aoc_01_parser: RTL and testbench

Upstream front end for the day-1 dial solver. It consumes the raw puzzle input as an ASCII byte stream (lines such as `L68`, `R30`), decodes each line into a direction bit and a decimal magnitude, and presents one registered single-cycle record per line to the solver's `dir`/`data`/`valid` inputs. It also flags malformed lines, counts records, and stops accepting input after the final byte of the file.

---
 rtl/aoc_01_parser_pkg.sv | 37 +++
 rtl/aoc_01_parser_if.sv | 29 ++
 rtl/aoc_01_parser_dec_accum.sv | 63 ++++++
 rtl/aoc_01_parser.sv | 188 ++++++++++++++++++
 tb/tb_aoc_01_parser.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aoc_01_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aoc_pkg
// Description : Shared ASCII constants, parser state encoding and character
//               helpers for the puzzle-input front ends.
// Revision    : 1.0 - initial release
// ============================================================================
package aoc_pkg;

    localparam logic [7:0] ASC_L  = 8'h4C;
    localparam logic [7:0] ASC_R  = 8'h52;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;

    typedef enum logic [1:0] {
        S_DIR  = 2'd0,
        S_NUM  = 2'd1,
        S_ERR  = 2'd2,
        S_DONE = 2'd3
    } parse_state_t;

    // True for the ASCII characters '0' through '9'.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

    // Numeric value of an ASCII digit; only meaningful when is_digit() holds.
    function automatic logic [3:0] digit_val(input logic [7:0] b);
        logic [7:0] w_off;
        w_off = b - ASC_0;
        return w_off[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aoc_01_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : aoc_01_parser_if
// Description : Byte-stream input and record-strobe output of the day-1
//               parser. The parser takes the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface aoc_01_parser_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              out_dir;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    modport master (
        output in_byte, in_valid, in_last,
        input  in_ready, out_dir, out_data, out_valid
    );

    modport slave (
        input  in_byte, in_valid, in_last,
        output in_ready, out_dir, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/aoc_01_parser_dec_accum.sv
`default_nettype none
// ============================================================================
// Module      : dec_accum
// Description : Saturating decimal accumulator. Each enabled digit performs
//               acc <= min(acc*10 + digit, 2^DATA_W-1); ovf is sticky once the
//               clamp has fired. The next-state values are exported so a
//               caller can capture a result on the same edge as the digit.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_accum #(
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clr,
    input  wire logic              en,
    input  wire logic [3:0]        digit,
    output logic      [DATA_W-1:0] acc,
    output logic                   ovf,
    output logic      [DATA_W-1:0] acc_nxt,
    output logic                   ovf_nxt
);
    // Four extra bits hold (2^DATA_W-1)*10 + 9 without wrapping.
    localparam int                  c_WIDE_W   = DATA_W + 4;
    localparam logic [c_WIDE_W-1:0] c_MAX_WIDE = {4'b0000, {DATA_W{1'b1}}};
    localparam logic [c_WIDE_W-1:0] c_TEN      = c_WIDE_W'(10);

    logic [DATA_W-1:0]   r_acc;
    logic                r_ovf;
    logic [c_WIDE_W-1:0] w_wide;
    logic                w_clamp;

    // Next accumulator value: clear wins, then digit update with clamp.
    always_comb begin
        w_wide  = ({4'b0000, r_acc} * c_TEN) + {{DATA_W{1'b0}}, digit};
        w_clamp = (w_wide > c_MAX_WIDE);
        acc_nxt = r_acc;
        ovf_nxt = r_ovf;
        if (clr) begin
            acc_nxt = '0;
            ovf_nxt = 1'b0;
        end else if (en) begin
            acc_nxt = w_clamp ? {DATA_W{1'b1}} : w_wide[DATA_W-1:0];
            ovf_nxt = r_ovf | w_clamp;
        end
    end

    // Accumulator and overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= acc_nxt;
            r_ovf <= ovf_nxt;
        end
    end

    assign acc = r_acc;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/aoc_01_parser.sv
`default_nettype none
// ============================================================================
// Module      : aoc_01_parser
// Description : Decodes an ASCII stream of "L<n>" / "R<n>" lines into one
//               registered single-cycle (dir, magnitude) record per line,
//               counts records, malformed lines and saturated magnitudes, and
//               stops accepting bytes after the in_last byte.
// Revision    : 1.0 - initial release
// ============================================================================
module aoc_01_parser
    import aoc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    aoc_01_parser_if.slave        bus,
    output logic      [CNT_W-1:0] rec_count,
    output logic      [CNT_W-1:0] err_count,
    output logic      [CNT_W-1:0] sat_count,
    output logic                  done
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    parse_state_t      r_state;
    parse_state_t      w_state_nxt;
    logic              r_dir;
    logic              w_dir_nxt;
    // Only "at least one digit seen" matters, so a flag stands in for a count.
    logic              r_has_digit;
    logic              w_has_digit_nxt;

    logic              w_accept;
    logic              w_emit;
    logic              w_err;
    logic              w_acc_clr;
    logic              w_acc_en;
    logic [3:0]        w_digit;
    logic [DATA_W-1:0] w_acc;
    logic [DATA_W-1:0] w_acc_nxt;
    logic              w_ovf;
    logic              w_ovf_nxt;
    logic [DATA_W-1:0] w_rec_data;
    logic              w_rec_ovf;

    logic              r_out_valid;
    logic              r_out_dir;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_rec_count;
    logic [CNT_W-1:0]  r_err_count;
    logic [CNT_W-1:0]  r_sat_count;

    assign bus.in_ready = (r_state != S_DONE) && !rst;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_digit      = digit_val(bus.in_byte);

    dec_accum #(
        .DATA_W (DATA_W)
    ) u_dec_accum (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_acc_clr),
        .en      (w_acc_en),
        .digit   (w_digit),
        .acc     (w_acc),
        .ovf     (w_ovf),
        .acc_nxt (w_acc_nxt),
        .ovf_nxt (w_ovf_nxt)
    );

    // A record closing on a digit byte (in_last without newline) must include
    // that digit, so take the accumulator's next value in that case.
    assign w_rec_data = w_acc_en ? w_acc_nxt : w_acc;
    assign w_rec_ovf  = w_acc_en ? w_ovf_nxt : w_ovf;

    // Next-state, accumulator control and record/error decisions per byte.
    always_comb begin
        w_state_nxt     = r_state;
        w_dir_nxt       = r_dir;
        w_has_digit_nxt = r_has_digit;
        w_acc_clr       = 1'b0;
        w_acc_en        = 1'b0;
        w_emit          = 1'b0;
        w_err           = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_DIR: begin
                    if ((bus.in_byte == ASC_L) || (bus.in_byte == ASC_R)) begin
                        w_dir_nxt       = (bus.in_byte == ASC_R);
                        w_acc_clr       = 1'b1;
                        w_has_digit_nxt = 1'b0;
                        w_state_nxt     = S_NUM;
                    end else if ((bus.in_byte != ASC_LF) && (bus.in_byte != ASC_CR)) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_ERR;
                    end
                end
                S_NUM: begin
                    if (is_digit(bus.in_byte)) begin
                        w_acc_en        = 1'b1;
                        w_has_digit_nxt = 1'b1;
                    end else if (bus.in_byte == ASC_LF) begin
                        w_emit      = r_has_digit;
                        w_err       = !r_has_digit;
                        w_state_nxt = S_DIR;
                    end else if (bus.in_byte != ASC_CR) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_ERR;
                    end
                end
                S_ERR: begin
                    if (bus.in_byte == ASC_LF) begin
                        w_state_nxt = S_DIR;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
            // End of file: close any line still open after this byte.
            if (bus.in_last) begin
                if (w_state_nxt == S_NUM) begin
                    w_emit = w_has_digit_nxt;
                    w_err  = !w_has_digit_nxt;
                end
                w_state_nxt = S_DONE;
            end
        end
    end

    // Parser state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_DIR;
            r_dir       <= 1'b0;
            r_has_digit <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dir       <= w_dir_nxt;
            r_has_digit <= w_has_digit_nxt;
        end
    end

    // Record output register; dir/data hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_dir   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_dir  <= w_dir_nxt;
                r_out_data <= w_rec_data;
            end
        end
    end

    // Saturating record, error and saturation counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec_count <= '0;
            r_err_count <= '0;
            r_sat_count <= '0;
        end else begin
            if (w_emit && (r_rec_count != c_CNT_MAX)) begin
                r_rec_count <= r_rec_count + 1'b1;
            end
            if (w_emit && w_rec_ovf && (r_sat_count != c_CNT_MAX)) begin
                r_sat_count <= r_sat_count + 1'b1;
            end
            if (w_err && (r_err_count != c_CNT_MAX)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_dir   = r_out_dir;
    assign bus.out_data  = r_out_data;
    assign rec_count     = r_rec_count;
    assign err_count     = r_err_count;
    assign sat_count     = r_sat_count;
    assign done          = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_aoc_01_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_aoc_01_parser
// Description : Self-checking bench for aoc_01_parser: directed stream table,
//               reset/latency sequences and a randomized line stream compared
//               with a numeric reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aoc_01_parser;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int NVEC   = 10;
    localparam int NLINES = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] rec_count;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] sat_count;
    logic             done;

    aoc_01_parser_if #(.DATA_W(DATA_W)) bus();

    aoc_01_parser #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .rec_count (rec_count),
        .err_count (err_count),
        .sat_count (sat_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string s;
        bit    last;
        int    n;
        int    exp[3];
        int    rec;
        int    err;
        int    sat;
        bit    dn;
    } vec_t;

    vec_t       vecs[NVEC];
    int         checks   = 0;
    int         failures = 0;
    logic [8:0] got_q[$];

    // Capture every record strobe as {dir, data}.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) got_q.push_back({bus.out_dir, bus.out_data});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mk(input bit d, input int v);
        int r;
        r = (d ? 256 : 0) + ((v > 255) ? 255 : v);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready actual=0 required=1");
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_str(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
    endtask

    task automatic send_gap(input logic [7:0] b, input bit last);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(b, last);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        got_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_vec(input int i, input string s, input bit last, input int n,
                           input int e0, input int e1, input int rec, input int err,
                           input int sat, input bit dn);
        vecs[i].s      = s;
        vecs[i].last   = last;
        vecs[i].n      = n;
        vecs[i].exp[0] = e0;
        vecs[i].exp[1] = e1;
        vecs[i].exp[2] = 0;
        vecs[i].rec    = rec;
        vecs[i].err    = err;
        vecs[i].sat    = sat;
        vecs[i].dn     = dn;
    endtask

    initial begin
        int         exp_q[$];
        int         sat_exp;
        logic [7:0] b;

        bus.in_byte  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        set_vec(0, "L68\nR30\n", 1'b0, 2, mk(0, 68), mk(1, 30), 2, 0, 0, 1'b0);
        set_vec(1, $sformatf("R5%c\n\nL0", 8'h0D), 1'b1, 2, mk(1, 5), mk(0, 0), 2, 0, 0, 1'b1);
        set_vec(2, "R300\nL255\n", 1'b0, 2, mk(1, 255), mk(0, 255), 2, 0, 1, 1'b0);
        set_vec(3, "X12\nL\nR7\n", 1'b0, 1, mk(1, 7), 0, 1, 2, 0, 1'b0);
        set_vec(4, "L12\nQ", 1'b1, 1, mk(0, 12), 0, 1, 1, 0, 1'b1);
        set_vec(5, "R7", 1'b1, 1, mk(1, 7), 0, 1, 0, 0, 1'b1);
        set_vec(6, "L42\n", 1'b1, 1, mk(0, 42), 0, 1, 0, 0, 1'b1);
        set_vec(7, "R", 1'b1, 0, 0, 0, 0, 1, 0, 1'b1);
        set_vec(8, $sformatf("L9x\nR1%c\n", 8'h0D), 1'b0, 1, mk(1, 1), 0, 1, 1, 0, 1'b0);
        set_vec(9, $sformatf("\n%cL256\n", 8'h0D), 1'b0, 1, mk(0, 255), 0, 1, 0, 1, 1'b0);

        // Reset state, sampled while rst is still high.
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_dir", int'(bus.out_dir), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_rec_count", int'(rec_count), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_sat_count", int'(sat_count), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(bus.in_ready), 1);

        // Directed stream table.
        for (int v = 0; v < NVEC; v++) begin
            do_reset();
            send_str(vecs[v].s, vecs[v].last);
            idle(4);
            check($sformatf("v%0d_strobes", v), got_q.size(), vecs[v].n);
            for (int k = 0; k < vecs[v].n; k++) begin
                check($sformatf("v%0d_rec%0d", v, k),
                      (k < got_q.size()) ? int'(got_q[k]) : -1, vecs[v].exp[k]);
            end
            check($sformatf("v%0d_rec_count", v), int'(rec_count), vecs[v].rec);
            check($sformatf("v%0d_err_count", v), int'(err_count), vecs[v].err);
            check($sformatf("v%0d_sat_count", v), int'(sat_count), vecs[v].sat);
            check($sformatf("v%0d_done", v), int'(done), int'(vecs[v].dn));
            check($sformatf("v%0d_in_ready", v), int'(bus.in_ready), vecs[v].dn ? 0 : 1);
        end

        // Strobe latency: high in the cycle right after LF, for one cycle only.
        do_reset();
        send_str("L5\n", 1'b0);
        idle(1);
        check("lat_valid_hi", int'(bus.out_valid), 1);
        check("lat_data", int'(bus.out_data), 5);
        check("lat_rec_count", int'(rec_count), 1);
        @(negedge clk);
        check("lat_valid_lo", int'(bus.out_valid), 0);
        check("lat_data_hold", int'(bus.out_data), 5);

        // Reset mid-line discards the partial record and clears counters.
        do_reset();
        send_str("L5\nL4", 1'b0);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_rec_count", int'(rec_count), 0);
        check("mid_rst_out_data", int'(bus.out_data), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 0);
        got_q.delete();
        @(negedge clk);
        rst = 1'b0;
        send_str("R9\n", 1'b0);
        idle(4);
        check("mid_rst_strobes", got_q.size(), 1);
        check("mid_rst_rec0", (got_q.size() > 0) ? int'(got_q[0]) : -1, mk(1, 9));
        check("mid_rst_rec_count_after", int'(rec_count), 1);
        check("mid_rst_err_count_after", int'(err_count), 0);

        // Random lines with gaps, checked against a numeric model.
        do_reset();
        sat_exp = 0;
        for (int ln = 0; ln < NLINES; ln++) begin
            bit d;
            int nd;
            int val;
            d   = 1'($urandom_range(0, 1));
            nd  = $urandom_range(1, 4);
            val = 0;
            if ($urandom_range(0, 7) == 0) send_gap(8'h0A, 1'b0);
            send_gap(d ? 8'h52 : 8'h4C, 1'b0);
            for (int k = 0; k < nd; k++) begin
                int dg;
                dg  = $urandom_range(0, 9);
                val = val * 10 + dg;
                b   = 8'h30 + 8'(dg);
                send_gap(b, 1'b0);
            end
            if ($urandom_range(0, 3) == 0) send_gap(8'h0D, 1'b0);
            send_gap(8'h0A, ln == NLINES - 1);
            exp_q.push_back(mk(d, val));
            if (val > 255) sat_exp++;
        end
        idle(4);
        check("rnd_strobes", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("rnd_rec%0d", k),
                  (k < got_q.size()) ? int'(got_q[k]) : -1, exp_q[k]);
        end
        check("rnd_rec_count", int'(rec_count), NLINES);
        check("rnd_sat_count", int'(sat_count), sat_exp);
        check("rnd_err_count", int'(err_count), 0);
        check("rnd_done", int'(done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
